// File: rtl/wb_pkg.sv
// Shared types for the writeback stage: result/load selectors and the M->W bundle.
package wb_pkg;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10,
        RES_RSV = 2'b11
    } result_src_t;

    typedef enum logic [2:0] {
        LT_B  = 3'b000,
        LT_H  = 3'b001,
        LT_W  = 3'b010,
        LT_BU = 3'b100,
        LT_HU = 3'b101
    } load_type_t;

    // Selector fields stay plain logic so reserved encodings can be carried unchanged.
    typedef struct packed {
        logic        valid;
        logic [31:0] alu_result;
        logic [31:0] pc_plus4;
        logic [4:0]  rd;
        logic        reg_write;
        logic [1:0]  result_src;
        logic [2:0]  load_type;
        logic        pc_src;
        logic        arm;
        logic [1:0]  offset;
    } mw_t;

endpackage

// File: rtl/load_ext.sv
// Load-data lane selection and sign/zero extension for the writeback stage.
module load_ext
    import wb_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  ltype,
    output logic [31:0] result
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        case (offset)
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            default: byte_v = word[31:24];
        endcase
        half_v = offset[1] ? word[31:16] : word[15:0];
    end

    // Reserved load types fall through to a full-word load.
    always_comb begin
        case (ltype)
            LT_B:    result = {{24{byte_v[7]}}, byte_v};
            LT_H:    result = {{16{half_v[15]}}, half_v};
            LT_BU:   result = {24'd0, byte_v};
            LT_HU:   result = {16'd0, half_v};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/stage_w.sv
// Writeback stage: M->W register, stall-safe load-data capture, result select,
// qualified register/PC writes and the retired-instruction counter.
module stage_w
    import wb_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int CNTW = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ValidM,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] PCPlus4M,
    input  logic [4:0]      RdM,
    input  logic            RegWriteM,
    input  logic [1:0]      ResultSrcM,
    input  logic [2:0]      LoadTypeM,
    input  logic            PCSrcM,
    input  logic            armM,
    input  logic [XLEN-1:0] ReadDataW,
    input  logic            StallW,
    input  logic            FlushW,
    output logic [XLEN-1:0] ResultW,
    output logic [4:0]      RdW,
    output logic            RegWriteW,
    output logic            PCSrcW,
    output logic            armW,
    output logic            ValidW,
    output logic [CNTW-1:0] InstRetW
);

    mw_t             mw_d, mw_q;
    logic [XLEN-1:0] cap_d, cap_q;
    logic            held_d, held_q;
    logic [CNTW-1:0] inst_ret_d, inst_ret_q;
    logic [XLEN-1:0] load_word;
    logic [XLEN-1:0] load_val;

    always_comb begin
        mw_d = mw_q;
        if (FlushW) begin
            mw_d = '0;
        end else if (!StallW) begin
            mw_d.valid      = ValidM;
            mw_d.alu_result = ALUResultM;
            mw_d.pc_plus4   = PCPlus4M;
            mw_d.rd         = RdM;
            mw_d.reg_write  = RegWriteM;
            mw_d.result_src = ResultSrcM;
            mw_d.load_type  = LoadTypeM;
            mw_d.pc_src     = PCSrcM;
            mw_d.arm        = armM;
            mw_d.offset     = ALUResultM[1:0];
        end
    end

    // The RAM output moves on during a stall, so the first stalled edge snapshots it.
    always_comb begin
        cap_d  = cap_q;
        held_d = 1'b0;
        if (StallW && !FlushW) begin
            held_d = 1'b1;
            if (!held_q) cap_d = ReadDataW;
        end
    end

    always_comb begin
        inst_ret_d = inst_ret_q;
        if (mw_q.valid && !StallW && !FlushW)
            inst_ret_d = inst_ret_q + {{(CNTW-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mw_q       <= '0;
            cap_q      <= '0;
            held_q     <= 1'b0;
            inst_ret_q <= '0;
        end else begin
            mw_q       <= mw_d;
            cap_q      <= cap_d;
            held_q     <= held_d;
            inst_ret_q <= inst_ret_d;
        end
    end

    assign load_word = held_q ? cap_q : ReadDataW;

    load_ext u_load_ext (
        .word   (load_word),
        .offset (mw_q.offset),
        .ltype  (mw_q.load_type),
        .result (load_val)
    );

    always_comb begin
        case (mw_q.result_src)
            RES_MEM: ResultW = load_val;
            RES_PC4: ResultW = mw_q.pc_plus4;
            default: ResultW = mw_q.alu_result;
        endcase
    end

    assign RdW       = mw_q.rd;
    assign armW      = mw_q.arm;
    assign ValidW    = mw_q.valid;
    assign RegWriteW = mw_q.reg_write & mw_q.valid & ~(~mw_q.arm & (mw_q.rd == 5'd0));
    assign PCSrcW    = mw_q.pc_src & mw_q.valid & mw_q.arm;
    assign InstRetW  = inst_ret_q;

endmodule

// File: tb/tb_stage_w.sv
// Bench for stage_w: directed vector table, stall/flush/wrap/reset sequences,
// and randomized traffic checked against a spec-level model.
module tb_stage_w;

    logic        clk;
    logic        rst;
    logic        ValidM;
    logic [31:0] ALUResultM;
    logic [31:0] PCPlus4M;
    logic [4:0]  RdM;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  LoadTypeM;
    logic        PCSrcM;
    logic        armM;
    logic [31:0] ReadDataW;
    logic        StallW;
    logic        FlushW;
    logic [31:0] ResultW;
    logic [4:0]  RdW;
    logic        RegWriteW;
    logic        PCSrcW;
    logic        armW;
    logic        ValidW;
    logic [63:0] InstRetW;

    stage_w #(.XLEN(32), .CNTW(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .ValidM     (ValidM),
        .ALUResultM (ALUResultM),
        .PCPlus4M   (PCPlus4M),
        .RdM        (RdM),
        .RegWriteM  (RegWriteM),
        .ResultSrcM (ResultSrcM),
        .LoadTypeM  (LoadTypeM),
        .PCSrcM     (PCSrcM),
        .armM       (armM),
        .ReadDataW  (ReadDataW),
        .StallW     (StallW),
        .FlushW     (FlushW),
        .ResultW    (ResultW),
        .RdW        (RdW),
        .RegWriteW  (RegWriteW),
        .PCSrcW     (PCSrcW),
        .armW       (armW),
        .ValidW     (ValidW),
        .InstRetW   (InstRetW)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic        rw;
        logic [1:0]  rs;
        logic [2:0]  lt;
        logic        pcs;
        logic        arm;
    } mrec_t;

    typedef struct {
        mrec_t       m;
        logic [31:0] data;
        logic [31:0] exp_res;
        logic        exp_rw;
        logic        exp_pcs;
    } vec_t;

    int          chk_cnt;
    int          pass_cnt;
    logic [63:0] ret_exp;
    mrec_t       bubble;
    vec_t        tbl[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- driver ----------------
    task automatic drive_m(input mrec_t r);
        ValidM     = r.valid;
        ALUResultM = r.alu;
        PCPlus4M   = r.pc4;
        RdM        = r.rd;
        RegWriteM  = r.rw;
        ResultSrcM = r.rs;
        LoadTypeM  = r.lt;
        PCSrcM     = r.pcs;
        armM       = r.arm;
    endtask

    function automatic mrec_t mk_m(input logic [31:0] alu, input logic [31:0] pc4, input logic [4:0] rd,
                                   input logic rw, input logic [1:0] rs, input logic [2:0] lt,
                                   input logic pcs, input logic arm);
        mrec_t r;
        r.valid = 1'b1; r.alu = alu; r.pc4 = pc4; r.rd = rd; r.rw = rw;
        r.rs = rs; r.lt = lt; r.pcs = pcs; r.arm = arm;
        return r;
    endfunction

    function automatic vec_t mk(input mrec_t m, input logic [31:0] data, input logic [31:0] res,
                                input logic erw, input logic epcs);
        vec_t v;
        v.m = m; v.data = data; v.exp_res = res; v.exp_rw = erw; v.exp_pcs = epcs;
        return v;
    endfunction

    function automatic mrec_t rand_rec();
        mrec_t r;
        r.valid = ($urandom_range(0, 4) != 0);
        r.alu   = $urandom();
        r.pc4   = $urandom();
        r.rd    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        r.rw    = 1'($urandom_range(0, 1));
        r.rs    = 2'($urandom_range(0, 3));
        r.lt    = 3'($urandom_range(0, 7));
        r.pcs   = 1'($urandom_range(0, 1));
        r.arm   = 1'($urandom_range(0, 1));
        return r;
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_result(input mrec_t r, input logic [31:0] d);
        int unsigned off;
        int unsigned b;
        int unsigned h;
        logic [31:0] ld;
        off = int'(r.alu[1:0]);
        b   = (d >> (8 * off)) & 32'hFF;
        h   = (d >> (16 * (off / 2))) & 32'hFFFF;
        case (r.lt)
            3'd0:    ld = (b >= 128) ? 32'(b) - 32'd256 : 32'(b);
            3'd1:    ld = (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h);
            3'd4:    ld = 32'(b);
            3'd5:    ld = 32'(h);
            default: ld = d;
        endcase
        if (r.rs == 2'd1)      return ld;
        else if (r.rs == 2'd2) return r.pc4;
        else                   return r.alu;
    endfunction

    function automatic logic model_rw(input mrec_t r);
        return r.rw && r.valid && (r.arm || r.rd != 5'd0);
    endfunction

    function automatic logic model_pcs(input mrec_t r);
        return r.pcs && r.valid && r.arm;
    endfunction

    // ---------------- stimulus + scoreboard ----------------
    initial begin
        mrec_t cur;
        mrec_t nxt;
        mrec_t tmp;
        logic [31:0] cur_data;
        logic fresh;
        logic stall;

        chk_cnt  = 0;
        pass_cnt = 0;
        ret_exp  = 64'd0;
        bubble   = '{default: '0};
        drive_m(bubble);
        ReadDataW = 32'h0;
        StallW    = 1'b0;
        FlushW    = 1'b0;
        rst       = 1'b0;

        tbl[0]  = mk(mk_m(32'h0000_1002, 32'h0, 5'd5, 1, 2'd1, 3'd0, 0, 0), 32'h1280_7F00, 32'hFFFF_FF80, 1, 0);
        tbl[1]  = mk(mk_m(32'h0000_1002, 32'h0, 5'd5, 1, 2'd1, 3'd4, 0, 0), 32'h1280_7F00, 32'h0000_0080, 1, 0);
        tbl[2]  = mk(mk_m(32'h0000_2002, 32'h0, 5'd6, 1, 2'd1, 3'd1, 0, 0), 32'h8001_0000, 32'hFFFF_8001, 1, 0);
        tbl[3]  = mk(mk_m(32'h0000_2002, 32'h0, 5'd6, 1, 2'd1, 3'd5, 0, 0), 32'h8001_0000, 32'h0000_8001, 1, 0);
        tbl[4]  = mk(mk_m(32'h0000_1003, 32'h0, 5'd7, 1, 2'd1, 3'd2, 0, 0), 32'hCAFE_F00D, 32'hCAFE_F00D, 1, 0);
        tbl[5]  = mk(mk_m(32'h1234_5678, 32'h0, 5'd0, 1, 2'd0, 3'd2, 0, 0), 32'h0,         32'h1234_5678, 0, 0);
        tbl[6]  = mk(mk_m(32'h0BAD_0001, 32'h0, 5'd0, 1, 2'd0, 3'd2, 0, 1), 32'h0,         32'h0BAD_0001, 1, 0);
        tbl[7]  = mk(mk_m(32'h0000_4000, 32'h0, 5'd15, 0, 2'd0, 3'd2, 1, 1), 32'h0,        32'h0000_4000, 0, 1);
        tbl[8]  = mk(mk_m(32'h0000_5000, 32'h0, 5'd3, 0, 2'd0, 3'd2, 1, 0), 32'h0,         32'h0000_5000, 0, 0);
        tbl[9]  = mk(mk_m(32'h0000_6000, 32'h104, 5'd1, 1, 2'd2, 3'd2, 0, 0), 32'h0,       32'h0000_0104, 1, 0);
        tbl[10] = mk(mk_m(32'h0000_7000, 32'h108, 5'd2, 1, 2'd3, 3'd2, 0, 0), 32'h0,       32'h0000_7000, 1, 0);
        tbl[11] = mk(mk_m(32'h0000_8001, 32'h0, 5'd9, 1, 2'd1, 3'd3, 0, 0), 32'hA5A5_0F0F, 32'hA5A5_0F0F, 1, 0);

        // reset state
        #12;
        check("rst_result", ResultW, 0);
        check("rst_rd", RdW, 0);
        check("rst_regwrite", RegWriteW, 0);
        check("rst_pcsrc", PCSrcW, 0);
        check("rst_arm", armW, 0);
        check("rst_valid", ValidW, 0);
        check("rst_instret", InstRetW, 0);
        @(negedge clk);
        rst = 1'b1;

        // directed vector table
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive_m(tbl[i].m);
            @(posedge clk);
            #1;
            drive_m(bubble);
            ReadDataW = tbl[i].data;
            #1;
            check($sformatf("vec%0d_result", i), ResultW, tbl[i].exp_res);
            check($sformatf("vec%0d_regwrite", i), RegWriteW, tbl[i].exp_rw);
            check($sformatf("vec%0d_pcsrc", i), PCSrcW, tbl[i].exp_pcs);
            check($sformatf("vec%0d_valid", i), ValidW, 1);
        end
        @(posedge clk);
        #1;
        ret_exp = 64'd12;
        check("table_instret", InstRetW, ret_exp);

        // stall with load capture: three stalled edges, then release
        @(negedge clk);
        drive_m(mk_m(32'h0000_2000, 32'h0, 5'd7, 1, 2'd1, 3'd2, 0, 0));
        @(posedge clk);
        #1;
        drive_m(bubble);
        ReadDataW = 32'hDEAD_BEEF;
        StallW = 1'b1;
        #1;
        check("stall_c0_result", ResultW, 32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            ReadDataW = 32'h1111_1111;
            if (i == 2) StallW = 1'b0;
            #1;
            check($sformatf("stall_c%0d_result", i + 1), ResultW, 32'hDEAD_BEEF);
            check($sformatf("stall_c%0d_instret", i + 1), InstRetW, ret_exp);
            check($sformatf("stall_c%0d_valid", i + 1), ValidW, 1);
        end
        @(posedge clk);
        #1;
        ret_exp = ret_exp + 1;
        check("stall_release_instret", InstRetW, ret_exp);
        check("stall_release_valid", ValidW, 0);

        // flush concurrent with stall on a valid load
        @(negedge clk);
        drive_m(mk_m(32'h0000_3000, 32'h0, 5'd8, 1, 2'd1, 3'd2, 0, 0));
        @(posedge clk);
        #1;
        drive_m(bubble);
        ReadDataW = 32'h7777_7777;
        StallW = 1'b1;
        FlushW = 1'b1;
        @(posedge clk);
        #1;
        StallW = 1'b0;
        FlushW = 1'b0;
        #1;
        check("flush_valid", ValidW, 0);
        check("flush_regwrite", RegWriteW, 0);
        check("flush_instret", InstRetW, ret_exp);
        check("flush_result", ResultW, 0);

        // randomized traffic with random stalls
        cur = bubble;
        cur_data = 32'h0;
        fresh = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            ReadDataW = fresh ? cur_data : 32'($urandom());
            #1;
            check("rand_result", ResultW, model_result(cur, cur_data));
            check("rand_valid", ValidW, cur.valid);
            check("rand_rd", RdW, cur.rd);
            check("rand_arm", armW, cur.arm);
            check("rand_regwrite", RegWriteW, model_rw(cur));
            check("rand_pcsrc", PCSrcW, model_pcs(cur));
            check("rand_instret", InstRetW, ret_exp);
            stall = ($urandom_range(0, 3) == 0);
            nxt = rand_rec();
            drive_m(nxt);
            StallW = stall;
            @(posedge clk);
            if (!stall) begin
                if (cur.valid) ret_exp = ret_exp + 1;
                cur = nxt;
                cur_data = $urandom();
                fresh = 1'b1;
            end else begin
                fresh = 1'b0;
            end
        end
        @(negedge clk);
        drive_m(bubble);
        StallW = 1'b0;
        @(posedge clk);
        #1;
        if (cur.valid) ret_exp = ret_exp + 1;
        check("rand_final_instret", InstRetW, ret_exp);

        // counter wrap
        @(negedge clk);
        force dut.inst_ret_q = '1;
        #1;
        release dut.inst_ret_q;
        #1;
        check("wrap_preload", InstRetW, 64'hFFFF_FFFF_FFFF_FFFF);
        drive_m(mk_m(32'h0000_0010, 32'h0, 5'd4, 1, 2'd0, 3'd2, 0, 0));
        @(posedge clk);
        #1;
        drive_m(bubble);
        @(posedge clk);
        #1;
        check("wrap_instret", InstRetW, 0);

        // asynchronous reset in the middle of a stall
        @(negedge clk);
        tmp = mk_m(32'h0000_0040, 32'h0, 5'd12, 1, 2'd1, 3'd2, 1, 1);
        drive_m(tmp);
        @(posedge clk);
        #1;
        drive_m(bubble);
        ReadDataW = 32'h5555_AAAA;
        StallW = 1'b1;
        @(posedge clk);
        #3;
        check("prereset_result", ResultW, 32'h5555_AAAA);
        rst = 1'b0;
        #1;
        check("areset_result", ResultW, 0);
        check("areset_rd", RdW, 0);
        check("areset_regwrite", RegWriteW, 0);
        check("areset_pcsrc", PCSrcW, 0);
        check("areset_arm", armW, 0);
        check("areset_valid", ValidW, 0);
        check("areset_instret", InstRetW, 0);
        @(negedge clk);
        StallW = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_valid", ValidW, 0);
        check("post_reset_result", ResultW, 0);

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
